ecpd: RTL and testbench
=======================

Name: ecpd

Overview:
- Elliptic-curve point doubler in Jacobian projective coordinates over a prime field GF(p): (X3,Y3,Z3) = 2·(X1,Y1,Z1).
- Curve form y² = x³ + 7, i.e. a = 0 (secp256k1 family); the modulus p is a run-time input.
- Sits under the scalar-multiplication controller of the ECDSA datapath; called once per double step.
- Multi-cycle, one shared iterative modular multiplier.

Parameters:
- WIDTH, 256, field element / modulus width in bits.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset; asynchronous and active-low.
- i_start  in  1  start request; level-sampled in IDLE.
- X1  in  WIDTH  input X, requirement X1 < p.
- Y1  in  WIDTH  input Y, requirement Y1 < p.
- Z1  in  WIDTH  input Z, requirement Z1 < p.
- p  in  WIDTH  odd prime modulus, p > 3.
- X3  out  WIDTH  result X, fully reduced to [0,p).
- Y3  out  WIDTH  result Y, fully reduced to [0,p).
- Z3  out  WIDTH  result Z, fully reduced to [0,p).
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; X3=Y3=Z3=0; o_done=0; all temporaries cleared. Reset asserted mid-operation aborts immediately and no done pulse follows.
- IDLE: on i_start=1, register X1,Y1,Z1,p and go to CALC. Inputs may change after this capture cycle.
- CALC sequence (all values mod p):
  - T1=Y1²
  - S=4·X1·T1
  - M=3·X1²
  - C8=8·T1²
  - X3=M²−2S
  - Y3=M·(S−X3)−C8
  - Z3=2·Y1·Z1
- Operation counts: 7 modular multiplications. Doublings/triplings use the modular add unit (a+b, then subtract p if ≥ p). Subtraction: a−b, add p if borrow.
- Modular multiply: MSB-first interleaved shift-add over 256 bits. acc = 2·acc + (bit ? a : 0), then up to two conditional subtractions of p. Intermediates are WIDTH+2 bits wide. One multiply takes exactly WIDTH+1 cycles (load + 256 iterations).
- Latency: data-independent constant L, from the i_start capture edge to the o_done pulse. L ≤ 1900 cycles at WIDTH=256; the implementation documents the exact L in the package.
- DONE: X3/Y3/Z3 registers updated, o_done=1 for exactly one cycle, then return to IDLE. Outputs hold until the next completion or reset.
- If i_start is still high in IDLE, a new operation starts immediately (back-to-back). Outputs change only at each completion.
- i_start during CALC is ignored.
- Degenerate inputs (Y1=0 or Z1=0) run the normal formula; Z3 naturally becomes 0 (point at infinity).

Optional Feature:
- Macro: ECPD_INF_CHECK_EN.
- Defined: at capture, if Y1==0 or Z1==0, skip CALC; output X3=1, Y3=1, Z3=0 with o_done pulsing 2 cycles after capture.
- Undefined: no check; full latency L; Z3=0 results from the formula, and X3/Y3 take whatever value the formula gives.

Decomposition:
- Package ecpd_pkg: WIDTH constant, latency constant ECPD_LATENCY, state enum (IDLE, CALC, DONE), micro-step enum for the CALC sequencer.
- Sub-module ecpd_modmul: iterative modular multiplier with start/done handshake, inputs a, b, p, output r < p. Instantiated once and reused for all 7 products.
- Modular add/sub stays as functions in ecpd.

Test Plan:
- Small field: p=23, X1=2, Y1=3, Z1=1 -> X3=0, Y3=9, Z3=6, one o_done pulse.
- secp256k1: p=FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, G=(79BE667E…16F81798, 483ADA77…FB10D4B8, 1) -> Z3=9075B4EE4D4788CABB49F7F81C221151FA2F68914D0AA833388FA11FF621A970. Affine X3/Z3² = C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, Y3/Z3³ = 1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A.
- Same G with p=2^256−189 (…FF43), i_start held high -> o_done pulses every L+1 cycles; outputs match the bench's golden model and are identical on every pulse.
- Y1=0, Z1=1, p=23 -> Z3=0. With ECPD_INF_CHECK_EN: (1,1,0) after 2 cycles.
- Deassert i_rst_n 500 cycles into CALC -> outputs 0 immediately, no o_done. Fresh start after release gives correct results.
- Check latency: count cycles from capture to o_done -> equals ECPD_LATENCY for random inputs.

Source files
------------

// File: rtl/ecpd_pkg.sv
// ecpd_pkg: shared constants and enums for the Jacobian point doubler (a = 0 curves).
package ecpd_pkg;
  localparam int WIDTH = 256;
  // capture edge to o_done: 7 products x (issue + WIDTH iterations + consume) + output load
  localparam int ECPD_LATENCY = 7 * (WIDTH + 2) + 1;
  localparam int ECPD_INF_LATENCY = 2;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [3:0] {ST_T1, ST_S, ST_M, ST_C8, ST_X3, ST_Y3, ST_Z3, ST_FIN, ST_INF} step_t;
endpackage

// File: rtl/ecpd_modmul.sv
// ecpd_modmul: MSB-first interleaved shift-add modular multiplier, r = a*b mod p, done WIDTH+1 cycles after start.
module ecpd_modmul
  import ecpd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] r,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] aq, bq, pq, acc_n;
  logic [CW-1:0] cnt;
  logic busy;
  logic [WIDTH+1:0] t, u, pe;
  // 2*acc + a < 3p, so two conditional subtractions fully reduce
  always_comb begin
    pe = {2'b0, pq};
    t = {1'b0, r, 1'b0} + {2'b0, {WIDTH{bq[WIDTH-1]}} & aq};
    u = t >= pe ? t - pe : t;
    acc_n = WIDTH'(u >= pe ? u - pe : u);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {aq, bq, pq, r, cnt, busy, done} <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        aq <= a;
        bq <= b;
        pq <= p;
        r <= '0;
        cnt <= CW'(WIDTH - 1);
        busy <= 1'b1;
      end else if (busy) begin
        r <= acc_n;
        bq <= bq << 1;
        cnt <= cnt - 1'b1;
        busy <= cnt != '0;
        done <= cnt == '0;
      end
    end
endmodule

// File: rtl/ecpd.sv
// ecpd: Jacobian point doubler 2*(X1,Y1,Z1) over GF(p) for y^2 = x^3 + 7, one shared modular multiplier.
// ECPD_INF_CHECK_EN: Y1==0 or Z1==0 short-circuits to (1,1,0) two cycles after capture.
module ecpd
  import ecpd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] Y1,
  input  logic [WIDTH-1:0] Z1,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] X3,
  output logic [WIDTH-1:0] Y3,
  output logic [WIDTH-1:0] Z3,
  output logic             o_done
);
  state_t state, state_n;
  step_t step;
  logic issued, mul_start, mul_done, capture;
  logic [WIDTH-1:0] x, y, z, pq, t1, s, m, c8, x3t, y3t, z3t, ma, mb, mr;

  function automatic logic [WIDTH-1:0] addm(input logic [WIDTH-1:0] a, b, md);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return WIDTH'(sum >= {1'b0, md} ? sum - {1'b0, md} : sum);
  endfunction

  function automatic logic [WIDTH-1:0] subm(input logic [WIDTH-1:0] a, b, md);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[WIDTH] ? d[WIDTH-1:0] + md : d[WIDTH-1:0];
  endfunction

  always_comb begin
    state_n = state;
    o_done = state == DONE;
    capture = (state == IDLE || state == DONE) && i_start;
    mul_start = state == CALC && !issued && step < ST_FIN;
    if (capture) state_n = CALC;
    else if (state == DONE) state_n = IDLE;
    else if (state == CALC && step == ST_FIN) state_n = DONE;
  end

  always_comb begin
    ma = y;
    mb = y;
    case (step)
      ST_S:  begin ma = x; mb = t1; end
      ST_M:  begin ma = x; mb = x; end
      ST_C8: begin ma = t1; mb = t1; end
      ST_X3: begin ma = m; mb = m; end
      ST_Y3: begin ma = m; mb = subm(s, x3t, pq); end
      ST_Z3: begin ma = y; mb = z; end
      default: ;
    endcase
  end

  ecpd_modmul u_mul (
    .clk(i_clk), .rst_n(i_rst_n), .start(mul_start),
    .a(ma), .b(mb), .p(pq), .r(mr), .done(mul_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      {x, y, z, pq, t1, s, m, c8, x3t, y3t, z3t, X3, Y3, Z3, issued} <= '0;
      step <= ST_T1;
    end else if (capture) begin
      x <= X1;
      y <= Y1;
      z <= Z1;
      pq <= p;
      issued <= 1'b0;
`ifdef ECPD_INF_CHECK_EN
      step <= (Y1 == '0 || Z1 == '0) ? ST_INF : ST_T1;
`else
      step <= ST_T1;
`endif
    end else if (state == CALC) begin
      if (mul_start) issued <= 1'b1;
      if (issued && mul_done) begin
        issued <= 1'b0;
        step <= step_t'(step + 4'd1);
        case (step)
          ST_T1: t1 <= mr;
          ST_S:  s <= addm(addm(mr, mr, pq), addm(mr, mr, pq), pq);
          ST_M:  m <= addm(addm(mr, mr, pq), mr, pq);
          ST_C8: c8 <= addm(addm(addm(mr, mr, pq), addm(mr, mr, pq), pq), addm(addm(mr, mr, pq), addm(mr, mr, pq), pq), pq);
          ST_X3: x3t <= subm(mr, addm(s, s, pq), pq);
          ST_Y3: y3t <= subm(mr, c8, pq);
          ST_Z3: z3t <= addm(mr, mr, pq);
          default: ;
        endcase
      end
      if (step == ST_INF) begin
        x3t <= WIDTH'(1);
        y3t <= WIDTH'(1);
        z3t <= '0;
        step <= ST_FIN;
      end
      if (step == ST_FIN) begin
        X3 <= x3t;
        Y3 <= y3t;
        Z3 <= z3t;
      end
    end
endmodule

// File: tb/tb_ecpd.sv
// tb_ecpd: table-driven scoreboard bench for the ecpd point doubler.
module tb_ecpd;
  import ecpd_pkg::*;
  typedef logic [WIDTH-1:0] fe_t;
  typedef struct {fe_t x, y, z, p, ex, ey, ez; int lat;} vec_t;

  localparam fe_t P_K1 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam fe_t P_2  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF43;
  localparam fe_t GX   = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam fe_t GY   = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam fe_t ZG2  = 256'h9075B4EE4D4788CABB49F7F81C221151FA2F68914D0AA833388FA11FF621A970;
  localparam fe_t AX   = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam fe_t AY   = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, done;
  fe_t x1 = '0, y1 = '0, z1 = '0, p = '0, x3, y3, z3, rx, ry, rz;
  int compared = 0, mismatched = 0;
  vec_t sb[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  ecpd dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .X1(x1), .Y1(y1), .Z1(z1), .p(p),
    .X3(x3), .Y3(y3), .Z3(z3), .o_done(done)
  );

  function automatic fe_t mulm(fe_t a, fe_t b, fe_t md);
    logic [2*WIDTH-1:0] pr;
    pr = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return fe_t'(pr % {{WIDTH{1'b0}}, md});
  endfunction

  function automatic fe_t addm(fe_t a, fe_t b, fe_t md);
    logic [WIDTH:0] sum;
    sum = ({1'b0, a} + {1'b0, b}) % {1'b0, md};
    return sum[WIDTH-1:0];
  endfunction

  function automatic fe_t subm(fe_t a, fe_t b, fe_t md);
    return addm(a, md - b, md);
  endfunction

  function automatic fe_t powm(fe_t b, fe_t e, fe_t md);
    fe_t r;
    r = fe_t'(1);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      r = mulm(r, r, md);
      if (e[i]) r = mulm(r, b, md);
    end
    return r;
  endfunction

  function automatic fe_t rnd(fe_t md);
    fe_t r;
    for (int k = 0; k < WIDTH / 32; k++) r[k*32 +: 32] = $urandom;
    return r % md;
  endfunction

  function automatic vec_t mk(fe_t x, fe_t y, fe_t z, fe_t md);
    vec_t v;
    fe_t t1, s, m, c8;
    v.x = x; v.y = y; v.z = z; v.p = md; v.lat = ECPD_LATENCY;
    t1 = mulm(y, y, md);
    s = mulm(fe_t'(4), mulm(x, t1, md), md);
    m = mulm(fe_t'(3), mulm(x, x, md), md);
    c8 = mulm(fe_t'(8), mulm(t1, t1, md), md);
    v.ex = subm(mulm(m, m, md), mulm(fe_t'(2), s, md), md);
    v.ey = subm(mulm(m, subm(s, v.ex, md), md), c8, md);
    v.ez = mulm(fe_t'(2), mulm(y, z, md), md);
`ifdef ECPD_INF_CHECK_EN
    if (y == '0 || z == '0) begin
      v.ex = fe_t'(1); v.ey = fe_t'(1); v.ez = '0; v.lat = ECPD_INF_LATENCY;
    end
`endif
    return v;
  endfunction

  task automatic chk(string nm, fe_t act, fe_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(vec_t v, string nm);
    vec_t e;
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    x1 = v.x; y1 = v.y; z1 = v.z; p = v.p; start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0; x1 = ~v.x; y1 = ~v.y; z1 = ~v.z; p = '0;
    while (!done && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    if (!done) begin
      compared++; mismatched++;
      $display("FAIL %s.timeout: no o_done after %0d cycles, expected at %0d", nm, cyc, e.lat);
      return;
    end
    chk({nm, ".x3"}, x3, e.ex);
    chk({nm, ".y3"}, y3, e.ey);
    chk({nm, ".z3"}, z3, e.ez);
    chk({nm, ".lat"}, fe_t'(cyc), fe_t'(e.lat));
    rx = x3; ry = y3; rz = z3;
    @(posedge clk); #1;
    chk({nm, ".pulse"}, fe_t'(done), '0);
    chk({nm, ".hold"}, z3, e.ez);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int cyc;
    logic seen;
    fe_t zi;
    tbl[0] = mk(fe_t'(2), fe_t'(3), fe_t'(1), fe_t'(23));
    tbl[0].ex = fe_t'(0); tbl[0].ey = fe_t'(9); tbl[0].ez = fe_t'(6);
    tbl[1] = mk(GX, GY, fe_t'(1), P_K1);
    tbl[2] = mk(fe_t'(5), fe_t'(0), fe_t'(1), fe_t'(23));
    tbl[3] = mk(fe_t'(7), fe_t'(11), fe_t'(0), fe_t'(23));
    tbl[4] = mk(GX, GY, fe_t'(1), P_2);
    for (int i = 5; i < 7; i++) tbl[i] = mk(rnd(P_K1), rnd(P_K1), rnd(P_K1), P_K1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.x3", x3, '0);
    chk("reset.y3", y3, '0);
    chk("reset.z3", z3, '0);
    chk("reset.done", fe_t'(done), '0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run(tbl[i], $sformatf("vec%0d", i));
      if (i == 1) begin
        chk("g2.z3_const", rz, ZG2);
        zi = powm(rz, P_K1 - fe_t'(2), P_K1);
        chk("g2.affine_x", mulm(rx, mulm(zi, zi, P_K1), P_K1), AX);
        chk("g2.affine_y", mulm(ry, mulm(zi, mulm(zi, zi, P_K1), P_K1), P_K1), AY);
      end
    end

    // i_start held high: back-to-back operations, one pulse every L+1 cycles
    @(posedge clk); #1;
    x1 = GX; y1 = GY; z1 = fe_t'(1); p = P_2; start = 1'b1;
    sb.push_back(tbl[4]);
    sb.push_back(tbl[4]);
    for (int k = 0; k < 2; k++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!done && cyc < 4000);
      if (k == 1) start = 1'b0;
      e = sb.pop_front();
      chk($sformatf("b2b%0d.period", k), fe_t'(cyc), fe_t'(ECPD_LATENCY + 1));
      chk($sformatf("b2b%0d.x3", k), x3, e.ex);
      chk($sformatf("b2b%0d.y3", k), y3, e.ey);
      chk($sformatf("b2b%0d.z3", k), z3, e.ez);
    end

    // reset 500 cycles into CALC aborts without a done pulse
    @(posedge clk); #1;
    x1 = fe_t'(2); y1 = fe_t'(3); z1 = fe_t'(1); p = fe_t'(23); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.x3", x3, '0);
    chk("abort.y3", y3, '0);
    chk("abort.z3", z3, '0);
    chk("abort.done", fe_t'(done), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (ECPD_LATENCY + 100) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort.no_done", fe_t'(seen), '0);
    run(tbl[0], "post_abort");
    run(tbl[2], "post_abort_y0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
